// File: rtl/tactile_pkg.sv
// Shared types and helpers for the tactile frame packer: sync bytes, reader states,
// result saturation and (dac, adc, phase) slot addressing.
package tactile_pkg;

  localparam logic [7:0] SYNC0_BYTE = 8'hA5;
  localparam logic [7:0] SYNC1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC0,
    ST_SYNC1,
    ST_SEQ,
    ST_FLAGS,
    ST_LO,
    ST_HI,
    ST_CSUM
  } rd_state_t;

  // Callers sign-extend their result to 64 bits so any OUT_BITS up to 63 fits.
  function automatic logic [15:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767) begin
      return 16'h7FFF;
    end else if (v < -64'sd32768) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  function automatic int unsigned slot_index(input int unsigned dac,
                                             input int unsigned adc,
                                             input logic        phase,
                                             input int unsigned adc_channels);
    return (dac * adc_channels + adc) * 2 + {31'b0, phase};
  endfunction

endpackage

// File: rtl/tactile_sample_bank.sv
// Two-bank sample store with per-bank written bitmaps; writes land one cycle later,
// reads are combinational and return zero for unwritten slots. No backpressure.
module tactile_sample_bank
  import tactile_pkg::*;
#(
  parameter int N           = 128,
  parameter int SLOT_W      = 7,
  parameter int SAMPLE_BITS = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [SLOT_W-1:0]      wr_slot,
  input  logic [SAMPLE_BITS-1:0] wr_data,
  input  logic                   clr_en,
  input  logic                   clr_bank,
  input  logic                   rd_bank,
  input  logic [SLOT_W-1:0]      rd_slot,
  output logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   rd_incomplete
);

  logic [SAMPLE_BITS-1:0] mem [2][N];
  logic [N-1:0]           bmp [2];

  // Sample storage needs no reset: the bitmap masks anything stale.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_slot] <= wr_data;
    end
  end

  // Clear beats a same-cycle set, so a dropped closing write leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmp[0] <= '0;
      bmp[1] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (clr_en && (clr_bank == b[0])) begin
          bmp[b] <= '0;
        end else if (wr_en && (wr_bank == b[0])) begin
          bmp[b][wr_slot] <= 1'b1;
        end
      end
    end
  end

  assign rd_data       = bmp[rd_bank][rd_slot] ? mem[rd_bank][rd_slot] : '0;
  assign rd_incomplete = ~&bmp[rd_bank];

endmodule

// File: rtl/tactile_frame_packer.sv
// Packs demodulator results into double-buffered frames and streams them as checksummed bytes.
// First byte two cycles after the closing write; m_data holds while m_ready is low; input never stalls.
module tactile_frame_packer
  import tactile_pkg::*;
#(
  parameter int DAC_CHANNELS = 8,
  parameter int ADC_CHANNELS = 8,
  parameter int OUT_BITS     = 32,
  parameter int SAMPLE_BITS  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [$clog2(DAC_CHANNELS)-1:0]   in_dac,
  input  logic [$clog2(ADC_CHANNELS)-1:0]   in_adc,
  input  logic                              in_phase,
  input  logic signed [OUT_BITS-1:0]        in_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [7:0]                        m_data,
  output logic [15:0]                       frame_drops
);

  localparam int N      = DAC_CHANNELS * ADC_CHANNELS * 2;
  localparam int SLOT_W = $clog2(N);
  localparam int DAC_W  = $clog2(DAC_CHANNELS);
  localparam int ADC_W  = $clog2(ADC_CHANNELS);
  localparam logic [DAC_W:0]    DAC_LIM   = DAC_CHANNELS[DAC_W:0];
  localparam logic [ADC_W:0]    ADC_LIM   = ADC_CHANNELS[ADC_W:0];
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N - 1);

  rd_state_t state, state_nxt;
  logic [SLOT_W-1:0]      rd_slot, slot_nxt;
  logic [7:0]             byte_nxt;
  logic [7:0]             seq;
  logic [7:0]             csum;
  logic [6:0]             pend, pend_tx;
  logic                   wr_bank;
  logic                   start_q;
  logic                   in_range, wr_en, close, accept, reader_free, swap, drop, load;
  logic [SLOT_W-1:0]      wr_slot;
  logic signed [63:0]     data_ext;
  logic [SAMPLE_BITS-1:0] sample;
  logic [SAMPLE_BITS-1:0] rd_data;
  logic                   rd_incomplete;

  assign in_range = ({1'b0, in_dac} < DAC_LIM) && ({1'b0, in_adc} < ADC_LIM);
  assign wr_en    = in_valid && in_range;
  assign wr_slot  = SLOT_W'(slot_index(32'(in_dac), 32'(in_adc), in_phase, ADC_CHANNELS));
  assign data_ext = {{(64-OUT_BITS){in_data[OUT_BITS-1]}}, in_data};
  assign sample   = sat16(data_ext);
  assign close    = wr_en && (wr_slot == LAST_SLOT);
  assign accept   = m_valid && m_ready;

  // A reader handing off its checksum this cycle is free; start_q covers the
  // one-cycle window between a swap and SYNC0 so a second close cannot re-swap.
  assign reader_free = ((state == ST_IDLE) && !start_q) || ((state == ST_CSUM) && accept);
  assign swap        = close && reader_free;
  assign drop        = close && !reader_free;
  assign load        = (state == ST_IDLE) ? start_q : accept;

  tactile_sample_bank #(
    .N           (N),
    .SLOT_W      (SLOT_W),
    .SAMPLE_BITS (SAMPLE_BITS)
  ) u_bank (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_slot       (wr_slot),
    .wr_data       (sample),
    .clr_en        (close),
    .clr_bank      (swap ? ~wr_bank : wr_bank),
    .rd_bank       (~wr_bank),
    .rd_slot       (slot_nxt),
    .rd_data       (rd_data),
    .rd_incomplete (rd_incomplete)
  );

  always_comb begin
    state_nxt = state;
    slot_nxt  = rd_slot;
    case (state)
      ST_IDLE:  if (start_q) state_nxt = ST_SYNC0;
      ST_SYNC0: if (accept)  state_nxt = ST_SYNC1;
      ST_SYNC1: if (accept)  state_nxt = ST_SEQ;
      ST_SEQ:   if (accept)  state_nxt = ST_FLAGS;
      ST_FLAGS: if (accept) begin
        state_nxt = ST_LO;
        slot_nxt  = '0;
      end
      ST_LO:    if (accept)  state_nxt = ST_HI;
      ST_HI:    if (accept) begin
        if (rd_slot == LAST_SLOT) begin
          state_nxt = ST_CSUM;
        end else begin
          state_nxt = ST_LO;
          slot_nxt  = rd_slot + 1'b1;
        end
      end
      ST_CSUM:  if (accept)  state_nxt = swap ? ST_SYNC0 : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Byte for the state being entered; the bank is addressed by slot_nxt.
  always_comb begin
    byte_nxt = '0;
    case (state_nxt)
      ST_SYNC0: byte_nxt = SYNC0_BYTE;
      ST_SYNC1: byte_nxt = SYNC1_BYTE;
      ST_SEQ:   byte_nxt = seq;
      ST_FLAGS: byte_nxt = {pend_tx, rd_incomplete};
      ST_LO:    byte_nxt = rd_data[7:0];
      ST_HI:    byte_nxt = rd_data[15:8];
      ST_CSUM:  byte_nxt = csum + m_data;
      default:  byte_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rd_slot     <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      start_q     <= 1'b0;
      wr_bank     <= 1'b0;
      seq         <= '0;
      csum        <= '0;
      pend        <= '0;
      pend_tx     <= '0;
      frame_drops <= '0;
    end else begin
      state   <= state_nxt;
      rd_slot <= slot_nxt;
      m_valid <= (state_nxt != ST_IDLE);
      start_q <= swap && (state == ST_IDLE);
      if (load) begin
        m_data <= byte_nxt;
      end
      if (swap) begin
        wr_bank <= ~wr_bank;
        pend_tx <= pend;
        pend    <= '0;
      end else if (drop && (pend != 7'h7F)) begin
        pend <= pend + 1'b1;
      end
      if (drop && (frame_drops != 16'hFFFF)) begin
        frame_drops <= frame_drops + 1'b1;
      end
      if (state == ST_SYNC0) begin
        csum <= '0;
      end else if (accept && (state inside {ST_SEQ, ST_FLAGS, ST_LO, ST_HI})) begin
        csum <= csum + m_data;
      end
      if (accept && (state == ST_CSUM)) begin
        seq <= seq + 1'b1;
      end
    end
  end

endmodule
